result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter CONV_CYCLES, default 8, number of shift-add-3 iterations; SHALL equal the value width.
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle strobe: capture the operand inputs and begin conversion.
REQ-005 value  input  8  unsigned arithmetic result to display.
REQ-006 add_sub_ovf  input  1  carry/overflow flag from add/subtract.
REQ-007 mult_div_ovf  input  2  decimal-point flags from multiply/divide.
REQ-008 hex0, hex1, hex2  output  8 each  active-low segments {dp,g..a} for ones, tens and hundreds digits.
REQ-009 ovf_led  output  1  registered copy of the captured add_sub_ovf.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  one-cycle pulse when the hex outputs update.

Function
REQ-012 FSM states SHALL be IDLE, CONVERT and UPDATE; IDLE->CONVERT on start, CONVERT->UPDATE after CONV_CYCLES iterations, UPDATE->IDLE unconditionally.
REQ-013 On start in IDLE, the block SHALL latch value, add_sub_ovf and mult_div_ovf in the same edge; inputs SHALL be don't-care afterwards.
REQ-014 CONVERT SHALL perform one double-dabble iteration per cycle on a 20-bit scratch register ({12-bit BCD, 8-bit binary}): add 3 to each BCD nibble >=5, then shift left by 1.
REQ-015 The iteration counter SHALL be 4 bits and SHALL NOT wrap within a conversion.
REQ-016 Latency: start sampled at edge N -> hex0..hex2, ovf_led updated and done high after edge N+CONV_CYCLES+1 (9 with default).
REQ-017 busy SHALL be high from the edge after start through the UPDATE cycle inclusive.
REQ-018 start asserted while busy SHALL be ignored (no re-capture, no restart).
REQ-019 start in the UPDATE cycle SHALL be ignored; start in the IDLE cycle after done SHALL be accepted.
REQ-020 Segment encoding per digit 0..9, active-low {g..a}: C0,F9,A4,B0,99,92,82,F8,80,90 (hex, dp bit = 1); BCD nibble >9 SHALL display 0xFF.
REQ-021 dp of hex0 SHALL be driven low when captured mult_div_ovf[0]=1; dp of hex1 low when mult_div_ovf[1]=1; dp of hex2 SHALL stay high.
REQ-022 Outputs SHALL hold the previous result during CONVERT (no flicker of partial values).

Reset
REQ-023 With rst_n=0 at a clock edge: state IDLE, counter 0, scratch 0, hex0=0xC0, hex1=0xC0, hex2=0xC0, ovf_led=0, busy=0, done=0.
REQ-024 Reset asserted mid-CONVERT SHALL abort the conversion; no done pulse SHALL follow it.

Configuration
REQ-025 Macro RESULT_DISPLAY_BLANK_EN: when defined, leading zero digits SHALL show 0xFF (hex2 blank if hundreds=0; hex1 blank if hundreds=0 and tens=0; hex0 never blanked); dp bits SHALL still follow REQ-021.
REQ-026 Without RESULT_DISPLAY_BLANK_EN, all three digits SHALL always show their numeric value, and reset values remain per REQ-023 in both builds.

Structure
REQ-027 Package result_display_pkg SHALL hold the FSM state typedef, the ten digit segment constants, SEG_BLANK=8'hFF and the CONV_CYCLES default.
REQ-028 One combinational sub-module seg7_decode (4-bit BCD in, 7-bit segments out) SHALL be instantiated three times; the FSM and double-dabble logic stay in result_display.

Verification
REQ-029 Reset then idle -> hex0/1/2=0xC0, busy=0, done=0, ovf_led=0.
REQ-030 start, value=255, flags 0 -> 9 cycles later done=1; hex2=0xA4, hex1=0x92, hex0=0x92.
REQ-031 start, value=7, add_sub_ovf=1 -> hex0=0xF8, ovf_led=1; hex1/hex2=0xC0 (0xFF with BLANK_EN).
REQ-032 start, value=100, mult_div_ovf=2'b11 -> hex2=0xF9, hex1=0x40, hex0=0x40.
REQ-033 Second start pulse 3 cycles into a conversion with value=9 -> result of first value shown, exactly one done pulse.
REQ-034 rst_n low at cycle 4 of CONVERT -> outputs return to reset values, no done pulse; next start converts normally.

Source files
------------

// File: rtl/result_display_pkg.sv
// Shared types and constants for the result_display block: FSM states,
// active-low seven-segment digit codes and the default conversion length.
package result_display_pkg;

    localparam int CONV_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_UPDATE
    } state_e;

    // Active-low {dp,g,f,e,d,c,b,a}, decimal point off
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/result_display_decode.sv
// seg7_decode: combinational BCD nibble to active-low {g..a} segments.
// Nibbles above 9 render as all segments off.
module seg7_decode
    import result_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK[6:0];
        case (bcd_i)
            4'd0: seg_o = SEG_0[6:0];
            4'd1: seg_o = SEG_1[6:0];
            4'd2: seg_o = SEG_2[6:0];
            4'd3: seg_o = SEG_3[6:0];
            4'd4: seg_o = SEG_4[6:0];
            4'd5: seg_o = SEG_5[6:0];
            4'd6: seg_o = SEG_6[6:0];
            4'd7: seg_o = SEG_7[6:0];
            4'd8: seg_o = SEG_8[6:0];
            4'd9: seg_o = SEG_9[6:0];
            default: seg_o = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Converts an 8-bit result to three decimal seven-segment digits via double-dabble.
// Optional macro RESULT_DISPLAY_BLANK_EN blanks leading zero digits.
module result_display
    import result_display_pkg::*;
#(
    parameter int CONV_CYCLES = CONV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value,
    input  logic       add_sub_ovf,
    input  logic [1:0] mult_div_ovf,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic       ovf_led,
    output logic       busy,
    output logic       done
);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [19:0] scratch_q;
    logic [19:0] scratch_d;
    logic        aso_q;
    logic [1:0]  mdo_q;
    logic [7:0]  hex0_q, hex1_q, hex2_q;
    logic [7:0]  hex0_d, hex1_d, hex2_d;
    logic        ovf_led_q, busy_q, done_q;
    logic [6:0]  seg0, seg1, seg2;
    logic        blank1, blank2;

    // One double-dabble step: correct BCD nibbles >= 5, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    assign scratch_d = dabble_step(scratch_q);

    seg7_decode u_dec0 (.bcd_i(scratch_q[11:8]),  .seg_o(seg0));
    seg7_decode u_dec1 (.bcd_i(scratch_q[15:12]), .seg_o(seg1));
    seg7_decode u_dec2 (.bcd_i(scratch_q[19:16]), .seg_o(seg2));

`ifdef RESULT_DISPLAY_BLANK_EN
    assign blank2 = (scratch_q[19:16] == 4'd0);
    assign blank1 = blank2 && (scratch_q[15:12] == 4'd0);
`else
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    // dp is active-low; the hundreds digit never shows a decimal point
    assign hex0_d = {~mdo_q[0], seg0};
    assign hex1_d = {~mdo_q[1], blank1 ? SEG_BLANK[6:0] : seg1};
    assign hex2_d = {1'b1,      blank2 ? SEG_BLANK[6:0] : seg2};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            scratch_q <= 20'd0;
            aso_q     <= 1'b0;
            mdo_q     <= 2'b00;
            hex0_q    <= SEG_0;
            hex1_q    <= SEG_0;
            hex2_q    <= SEG_0;
            ovf_led_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        scratch_q <= {12'd0, value};
                        cnt_q     <= 4'd0;
                        aso_q     <= add_sub_ovf;
                        mdo_q     <= mult_div_ovf;
                        busy_q    <= 1'b1;
                        state_q   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == 4'(CONV_CYCLES - 1))
                        state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    hex0_q    <= hex0_d;
                    hex1_q    <= hex1_d;
                    hex2_q    <= hex2_d;
                    ovf_led_q <= aso_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hex0    = hex0_q;
    assign hex1    = hex1_q;
    assign hex2    = hex2_q;
    assign ovf_led = ovf_led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: directed vector table, random values against a
// decimal-digit reference model, and hand sequences for restart/reset corners.
module tb_result_display;

`ifdef RESULT_DISPLAY_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif
    localparam logic [7:0] SEGTAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] value = 8'd0;
    logic       add_sub_ovf = 1'b0;
    logic [1:0] mult_div_ovf = 2'b00;
    logic [7:0] hex0, hex1, hex2;
    logic       ovf_led, busy, done;

    int n_pass = 0;
    int n_total = 0;

    result_display dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .add_sub_ovf(add_sub_ovf), .mult_div_ovf(mult_div_ovf),
        .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .ovf_led(ovf_led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic       aso;
        logic [1:0] mdo;
        logic [7:0] h2, h1, h0;
        logic       led;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: digit of a decimal number -> segment code with dp and blanking
    function automatic logic [7:0] exp_seg(input int v, input logic [1:0] mdo, input int pos);
        int d;
        logic [7:0] s;
        d = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
        s = SEGTAB[d];
        if (BL && pos == 2 && v < 100) s = 8'hFF;
        if (BL && pos == 1 && v < 10)  s = 8'hFF;
        if (pos < 2 && mdo[pos]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic check_outs(input string tag, input logic [7:0] e2, e1, e0, input logic el);
        check({tag, ".hex2"}, hex2, e2);
        check({tag, ".hex1"}, hex1, e1);
        check({tag, ".hex0"}, hex0, e0);
        check({tag, ".ovf_led"}, ovf_led, el);
    endtask

    // Full conversion: strobe start, hold-check mid-conversion, latency, outputs, one-cycle done
    task automatic run_conv(input string tag, input logic [7:0] v, input logic aso,
                            input logic [1:0] mdo, input logic [7:0] e2, e1, e0, input logic el);
        logic [7:0] p0, p1, p2;
        int lat;
        p0 = hex0; p1 = hex1; p2 = hex2;
        @(negedge clk);
        value = v; add_sub_ovf = aso; mult_div_ovf = mdo; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = 8'($urandom); add_sub_ovf = 1'($urandom); mult_div_ovf = 2'($urandom);
        check({tag, ".busy_start"}, busy, 1'b1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                check({tag, ".hold"}, {hex2, hex1, hex0}, {p2, p1, p0});
            end
        end
        check({tag, ".latency"}, lat, 9);
        check_outs(tag, e2, e1, e0, el);
        @(negedge clk);
        check({tag, ".done_pulse"}, {done, busy}, 2'b00);
    endtask

    vec_t tbl[6];

    initial begin
        int ndone;
        logic [7:0] c0, c1, c2;
        int lat;
        logic [7:0] rv;
        logic ra;
        logic [1:0] rm;

        tbl[0] = '{8'd255, 1'b0, 2'b00, 8'hA4, 8'h92, 8'h92, 1'b0};
        tbl[1] = '{8'd7,   1'b1, 2'b00, BL ? 8'hFF : 8'hC0, BL ? 8'hFF : 8'hC0, 8'hF8, 1'b1};
        tbl[2] = '{8'd100, 1'b0, 2'b11, 8'hF9, 8'h40, 8'h40, 1'b0};
        tbl[3] = '{8'd0,   1'b0, 2'b00, BL ? 8'hFF : 8'hC0, BL ? 8'hFF : 8'hC0, 8'hC0, 1'b0};
        tbl[4] = '{8'd9,   1'b0, 2'b01, BL ? 8'hFF : 8'hC0, BL ? 8'hFF : 8'hC0, 8'h10, 1'b0};
        tbl[5] = '{8'd42,  1'b1, 2'b10, BL ? 8'hFF : 8'hC0, 8'h19, 8'hA4, 1'b1};

        // Reset then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outs("reset", 8'hC0, 8'hC0, 8'hC0, 1'b0);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);

        for (int i = 0; i < 6; i++)
            run_conv($sformatf("vec%0d", i), tbl[i].v, tbl[i].aso, tbl[i].mdo,
                     tbl[i].h2, tbl[i].h1, tbl[i].h0, tbl[i].led);

        // Second start 3 cycles into a conversion is ignored
        @(negedge clk);
        value = 8'd123; add_sub_ovf = 1'b0; mult_div_ovf = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        value = 8'd9; mult_div_ovf = 2'b10; add_sub_ovf = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; c0 = 8'h00; c1 = 8'h00; c2 = 8'h00;
        repeat (24) begin
            @(negedge clk);
            if (done) begin
                ndone++; c0 = hex0; c1 = hex1; c2 = hex2;
            end
        end
        check("restart.ndone", ndone, 1);
        check("restart.hex", {c2, c1, c0},
              {exp_seg(123, 2'b01, 2), exp_seg(123, 2'b01, 1), exp_seg(123, 2'b01, 0)});
        check("restart.led", ovf_led, 1'b0);

        // Start in UPDATE ignored, start in the done cycle accepted
        @(negedge clk);
        value = 8'd56; add_sub_ovf = 1'b0; mult_div_ovf = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        value = 8'd99; start = 1'b1;
        @(negedge clk);
        check("upd.done", done, 1'b1);
        check("upd.hex", {hex2, hex1, hex0},
              {exp_seg(56, 2'b00, 2), exp_seg(56, 2'b00, 1), exp_seg(56, 2'b00, 0)});
        value = 8'd31; mult_div_ovf = 2'b01;
        @(negedge clk);
        start = 1'b0;
        check("upd.busy_accept", busy, 1'b1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("upd.latency", lat, 9);
        check("upd.result", {hex2, hex1, hex0},
              {exp_seg(31, 2'b01, 2), exp_seg(31, 2'b01, 1), exp_seg(31, 2'b01, 0)});

        // Reset during CONVERT aborts, then a normal conversion follows
        run_conv("pre_rst", 8'd255, 1'b1, 2'b11, exp_seg(255, 2'b11, 2),
                 exp_seg(255, 2'b11, 1), exp_seg(255, 2'b11, 0), 1'b1);
        @(negedge clk);
        value = 8'd200; add_sub_ovf = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outs("midrst", 8'hC0, 8'hC0, 8'hC0, 1'b0);
        check("midrst.busy", busy, 1'b0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst.ndone", ndone, 0);
        run_conv("post_rst", 8'd88, 1'b0, 2'b10, exp_seg(88, 2'b10, 2),
                 exp_seg(88, 2'b10, 1), exp_seg(88, 2'b10, 0), 1'b0);

        // Random values against the decimal reference
        for (int k = 0; k < 30; k++) begin
            rv = 8'($urandom);
            ra = 1'($urandom);
            rm = 2'($urandom_range(0, 3));
            run_conv($sformatf("rnd%0d_v%0d", k, rv), rv, ra, rm,
                     exp_seg(int'(rv), rm, 2), exp_seg(int'(rv), rm, 1),
                     exp_seg(int'(rv), rm, 0), ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
